// File: rtl/mccu_pkg.sv
// mccu_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - FSM state encodings (state_t)
//   - opcode / function-field constants for the decoded subset
//   - ALU opcode, ALU B-select and PC-source select codes
//   - instr_t: one-hot instruction flags produced by mccu_decode
//   - helpers: aluc_of (ALU opcode per instruction), is_itype
package mccu_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    // op field
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // func field (R-type only)
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU opcodes
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_RS     = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_lui;
        logic i_j;
        logic i_jal;
        logic valid;
    } instr_t;

    function automatic logic [3:0] aluc_of(input instr_t d);
        if (d.i_sub)                              return ALUC_SUB;
        else if (d.i_and || d.i_andi)             return ALUC_AND;
        else if (d.i_or || d.i_ori)               return ALUC_OR;
        else if (d.i_xor || d.i_xori || d.i_beq || d.i_bne) return ALUC_XOR;
        else if (d.i_lui)                         return ALUC_LUI;
        else if (d.i_sll)                         return ALUC_SLL;
        else if (d.i_srl)                         return ALUC_SRL;
        else if (d.i_sra)                         return ALUC_SRA;
        else                                      return ALUC_ADD;
    endfunction

    // Instructions whose ALU B operand is the extended immediate and whose
    // destination register is rt.
    function automatic logic is_itype(input instr_t d);
        return d.i_addi | d.i_andi | d.i_ori | d.i_xori | d.i_lw | d.i_sw | d.i_lui;
    endfunction

endpackage

// File: rtl/mccu_if.sv
// mccu_if: unified instruction/data memory handshake between the control
// unit (master) and the memory port (slave).
//   mem_req   request an access this cycle
//   iord      address select: 0 = PC, 1 = ALUout
//   wmem      write strobe, held for the whole wait
//   mem_ready memory completes the access this cycle
//   mem_err   one-cycle pulse when an access times out
interface mccu_if;
    logic mem_req;
    logic iord;
    logic wmem;
    logic mem_ready;
    logic mem_err;

    modport master (
        output mem_req,
        output iord,
        output wmem,
        output mem_err,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  iord,
        input  wmem,
        input  mem_err,
        output mem_ready
    );
endinterface

// File: rtl/mccu_decode.sv
// mccu_decode: combinational op/func decode into one-hot instruction flags.
//   op    in  IR[31:26]
//   func  in  IR[5:0]
//   instr out one-hot flags plus valid (set when any flag is set)
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     instr
);

    logic rtype;
    assign rtype = (op == OP_RTYPE);

    always_comb begin
        instr        = '0;
        instr.i_add  = rtype && (func == FN_ADD);
        instr.i_sub  = rtype && (func == FN_SUB);
        instr.i_and  = rtype && (func == FN_AND);
        instr.i_or   = rtype && (func == FN_OR);
        instr.i_xor  = rtype && (func == FN_XOR);
        instr.i_sll  = rtype && (func == FN_SLL);
        instr.i_srl  = rtype && (func == FN_SRL);
        instr.i_sra  = rtype && (func == FN_SRA);
        instr.i_jr   = rtype && (func == FN_JR);
        instr.i_addi = (op == OP_ADDI);
        instr.i_andi = (op == OP_ANDI);
        instr.i_ori  = (op == OP_ORI);
        instr.i_xori = (op == OP_XORI);
        instr.i_lw   = (op == OP_LW);
        instr.i_sw   = (op == OP_SW);
        instr.i_beq  = (op == OP_BEQ);
        instr.i_bne  = (op == OP_BNE);
        instr.i_lui  = (op == OP_LUI);
        instr.i_j    = (op == OP_J);
        instr.i_jal  = (op == OP_JAL);
        instr.valid  = instr.i_add  | instr.i_sub  | instr.i_and  | instr.i_or   |
                       instr.i_xor  | instr.i_sll  | instr.i_srl  | instr.i_sra  |
                       instr.i_jr   | instr.i_addi | instr.i_andi | instr.i_ori  |
                       instr.i_xori | instr.i_lw   | instr.i_sw   | instr.i_beq  |
                       instr.i_bne  | instr.i_lui  | instr.i_j    | instr.i_jal;
    end

endmodule

// File: rtl/mccu_fsm.sv
// mccu_fsm: multi-cycle MIPS control unit (IF/ID/EXE/MEM/WB sequencer).
// Optional feature macro: MCCU_ILLEGAL_TRAP_EN (adds the `illegal` output
// and traps undecoded instructions through the jump-target PC source).
//
// state | meaning
// ------+--------------------------------------------------------------
// IF    | fetch at PC, PC <= PC+4 and IR load on the ready cycle
// ID    | decode, ALUout <= branch target; j/jal/jr complete here
// EXE   | ALU operation; branches resolve here
// MEM   | data access at ALUout (lw/sw)
// WB    | register-file write (ALU result or memory data)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   op, func, z      IR fields and ALU zero flag
//   mem              memory handshake (mccu_if.master)
//   wir..pcsource    datapath enables and mux selects
//   state            current state
//   illegal          (macro only) one-cycle pulse on undecoded instruction
module mccu_fsm
    import mccu_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int TIMEOUT  = 15,
    parameter int FAST_MEM = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    mccu_if.master     mem,
    output logic       wir,
    output logic       wpc,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       shift,
    output logic       sext,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state
`ifdef MCCU_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    instr_t            d;
    logic              ready, in_access, timeout;
    logic              wir_c, wpc_c, wreg_c, wmem_c, illegal_c;

    mccu_decode u_decode (
        .op    (op),
        .func  (func),
        .instr (d)
    );

    assign ready     = mem.mem_ready | (FAST_MEM != 0);
    assign in_access = (state_q == ST_IF) || (state_q == ST_MEM);
    // A ready response on the terminal wait cycle still wins over the timeout.
    assign timeout   = in_access && !ready && (cnt_q == WAIT_W'(TIMEOUT));

    // Counter only runs while an access is stalled; any ready cycle, timeout
    // or state change returns it to zero.
    always_comb begin
        cnt_d = '0;
        if (in_access && !ready && !timeout)
            cnt_d = cnt_q + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IF;
            cnt_q       <= '0;
            mem.mem_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem.mem_err <= timeout;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem.mem_req = 1'b0;
        mem.iord    = 1'b0;
        wmem_c      = 1'b0;
        wir_c       = 1'b0;
        wpc_c       = 1'b0;
        wreg_c      = 1'b0;
        regrt       = 1'b0;
        m2reg       = 1'b0;
        jal         = 1'b0;
        shift       = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_RT;
        aluc        = ALUC_ADD;
        pcsource    = PCS_ALU;
        illegal_c   = 1'b0;

        unique case (state_q)
            ST_IF: begin
                mem.mem_req = 1'b1;
                alusrcb     = SRCB_FOUR;
                if (timeout) begin
                    state_d = ST_IF;
                end else if (ready) begin
                    wir_c   = 1'b1;
                    wpc_c   = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                alusrcb = SRCB_BRANCH;
                if (d.i_j || d.i_jal) begin
                    wpc_c    = 1'b1;
                    pcsource = PCS_JUMP;
                    wreg_c   = d.i_jal;
                    jal      = d.i_jal;
                    state_d  = ST_IF;
                end else if (d.i_jr) begin
                    wpc_c    = 1'b1;
                    pcsource = PCS_RS;
                    state_d  = ST_IF;
                end else if (d.valid) begin
                    state_d = ST_EXE;
                end else begin
`ifdef MCCU_ILLEGAL_TRAP_EN
                    // Datapath substitutes the trap vector on the jump input.
                    illegal_c = 1'b1;
                    wpc_c     = 1'b1;
                    pcsource  = PCS_JUMP;
`endif
                    state_d = ST_IF;
                end
            end
            ST_EXE: begin
                alusrca = 1'b1;
                alusrcb = is_itype(d) ? SRCB_IMM : SRCB_RT;
                shift   = d.i_sll | d.i_srl | d.i_sra;
                aluc    = aluc_of(d);
                if (d.i_beq || d.i_bne) begin
                    pcsource = PCS_ALUOUT;
                    wpc_c    = d.i_beq ? z : ~z;
                    state_d  = ST_IF;
                end else if (d.i_lw || d.i_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                wmem_c      = d.i_sw;
                if (timeout)
                    state_d = ST_IF;
                else if (ready)
                    state_d = d.i_sw ? ST_IF : ST_WB;
            end
            ST_WB: begin
                wreg_c  = 1'b1;
                m2reg   = d.i_lw;
                regrt   = d.i_addi | d.i_andi | d.i_ori | d.i_xori | d.i_lw | d.i_lui;
                state_d = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
    end

    // IR is stale during IF, so the immediate-extension select only follows
    // the decode once the new instruction is loaded.
    assign sext = (state_q != ST_IF) && (d.i_addi | d.i_lw | d.i_sw | d.i_beq | d.i_bne);

    // Reset abandons any in-flight access: no state-changing strobe escapes
    // during the reset cycle.
    assign wir      = wir_c  & ~rst;
    assign wpc      = wpc_c  & ~rst;
    assign wreg     = wreg_c & ~rst;
    assign mem.wmem = wmem_c & ~rst;
    assign state    = state_q;

`ifdef MCCU_ILLEGAL_TRAP_EN
    assign illegal = illegal_c & ~rst;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_c;
`endif

endmodule

// File: doc/mccu_fsm.md
Name: mccu_fsm

Overview:
- Multi-cycle MIPS control unit; successor to the single-cycle combinational controller.
- Decodes the same 20-instruction subset and sequences each instruction through IF/ID/EXE/MEM/WB states. Each state drives datapath enables and mux selects.
- Adds a variable-latency memory handshake with a wait timeout, and a compile-time single-cycle-memory mode.
- Sits between the shared multi-cycle datapath (PC, IR, regfile, ALU, ALUout register) and the unified instruction/data memory port.

Parameters:
- WAIT_W, 4: width of the memory-wait counter.
- TIMEOUT, 15: wait cycles before mem_err; must be < 2**WAIT_W.
- FAST_MEM, 0: 1 = ignore mem_ready and treat memory as always ready, so IF and MEM each take one cycle.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- op  in  6  IR[31:26]; registered in IR, stable from ID onward
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag, valid in EXE
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0 = PC, 1 = ALUout
- wmem  out  1  memory write
- wir  out  1  IR load enable
- wpc  out  1  PC load enable
- wreg  out  1  register-file write
- regrt  out  1  destination select: 1 = rt, 0 = rd
- m2reg  out  1  write-back select: 1 = memory data
- jal  out  1  destination forced to $31; write data is PC
- shift  out  1  ALU A operand = sa
- sext  out  1  sign-extend imm16
- alusrca  out  1  ALU A: 0 = PC, 1 = rs (or sa when shift=1)
- alusrcb  out  2  ALU B: 00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- aluc  out  4  ALU opcode
- pcsource  out  2  PC source: 00 = ALU, 01 = ALUout, 10 = rs, 11 = jump target
- state  out  3  current state (IF=0, ID=1, EXE=2, MEM=3, WB=4)
- mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (synchronous, rst=1 at the rising edge):
  - state goes to IF and the wait counter clears.
  - Every output is 0 except mem_req and alusrcb. In IF, mem_req=1 and alusrcb=01 are the IF decode, so they are 1 and 01 respectively in the cycle after reset.
  - rst mid-access abandons the access; no wpc/wreg/wmem occurs in the reset cycle.
- Outputs are a combinational decode of the registered state plus op/func/z. No other output registers except mem_err.
- Decode encodings:
  - R-type (op=000000) func: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
  - op: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111, j 000010, jal 000011.
- aluc encodings: add/addi/lw/sw 0000, sub 0100, and/andi 0001, or/ori 0101, xor/xori/beq/bne 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- sext=1 for addi, lw, sw, beq, bne.
- IF:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, pcsource=00, aluc=0000.
  - On a ready cycle: wir=1, wpc=1, go to ID. Otherwise hold IF.
- ID:
  - alusrca=0, alusrcb=11; ALUout latches the branch target.
  - j/jal: wpc=1, pcsource=11, go to IF. jal additionally asserts wreg=1 and jal=1 (PC already holds pc+4).
  - jr: wpc=1, pcsource=10, go to IF.
  - All other decoded instructions go to EXE.
  - Undecoded op/func go to IF without side effects (default build).
- EXE:
  - ALU op per aluc; alusrca=1; alusrcb=10 for I-type, 00 for R-type and branches; shift=1 for sll/srl/sra.
  - beq: wpc=z, pcsource=01. bne: wpc=~z, pcsource=01. Branches then go to IF.
  - lw/sw go to MEM; every other instruction goes to WB.
- MEM:
  - mem_req=1, iord=1; wmem=1 for sw, held for the whole wait.
  - Ready cycle: sw goes to IF, lw goes to WB.
- WB:
  - wreg=1; m2reg=1 for lw; regrt=1 for addi/andi/ori/xori/lw/lui.
  - Always goes to IF next.
- Memory wait counter:
  - A ready cycle is one with mem_ready=1 or FAST_MEM=1.
  - The counter increments each non-ready cycle in IF/MEM and clears on a ready cycle or on a state change.
  - If the counter reaches TIMEOUT with mem_ready still 0: mem_err pulses for one cycle, the access is dropped (no wir/wpc/wreg), the counter clears, and state goes to IF. PC is not advanced, so fetch retries.
  - mem_ready=1 in the same cycle the counter hits TIMEOUT counts as success; no error.
- Branch targets are computed in ID for all instructions; harmless when unused.

Optional Feature:
- Macro: MCCU_ILLEGAL_TRAP_EN.
- Defined: adds output `illegal` (1 bit). An undecoded op/func in ID pulses illegal for one cycle, asserts wpc=1 with pcsource=11, and goes to IF. The datapath supplies the trap vector on the jump-target input when illegal=1.
- Undefined: no illegal port; undecoded instructions behave as NOPs (ID to IF).

Decomposition:
- Package mccu_pkg:
  - state encodings;
  - op/func localparams;
  - aluc codes;
  - alusrcb/pcsource select codes.
- Sub-module mccu_decode: combinational op/func to one-hot instruction flags (i_add … i_jal, plus a valid flag). The FSM and output logic stay in mccu_fsm.

Test Plan:
- add, mem_ready=1 throughout: state sequence IF,ID,EXE,WB,IF over 4 cycles. aluc=0000 in EXE; wreg=1 and regrt=0 in WB; wpc=1 only in IF.
- lw with mem_ready=0 for 3 MEM cycles then 1: MEM held 4 cycles with iord=1, then WB with m2reg=1, wreg=1, regrt=1. Total 8 cycles; no mem_err.
- beq z=1 → wpc=1, pcsource=01 in EXE; repeat with z=0 → wpc=0. bne with z=0 → wpc=1. Each branch takes 3 cycles.
- jal → ID asserts wpc=1, pcsource=11, wreg=1, jal=1, then IF next cycle. jr → pcsource=10 in ID.
- IF with mem_ready held 0, TIMEOUT=15 → mem_err pulses once after 15 wait cycles; wir never asserted; state stays IF and the counter restarts.
- rst asserted in MEM of an sw → next cycle state=IF and wmem=0; wreg/wpc=0 in the reset cycle.
- Illegal op 111111 with the macro defined → illegal=1 for one cycle in ID, wpc=1, pcsource=11. Without the macro → ID then IF with no enables asserted.
